// File: rtl/n_perm_comb_seq.sv
// Sequential nPr / nCr engine: one operand pair per start, iterative product with an
// exact restoring divide per step for nCr, and error/overflow reporting.
module n_perm_comb_seq #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] n,
    input  logic [W-1:0] r,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] out,
    output logic         err,
    output logic         ovf
);

    localparam int CNT_W = $clog2(2 * W);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(2 * W - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic             r_mode;
    logic [W-1:0]     r_n;
    logic [W-1:0]     r_r;
    logic [W-1:0]     r_k;
    logic [W-1:0]     r_i;
    logic [2*W-1:0]   r_acc;
    logic [W-1:0]     r_rem;
    logic [CNT_W-1:0] r_divCnt;
    logic [W-1:0]     r_out;
    logic             r_err;
    logic             r_ovf;

    logic             w_rGtN;
    logic [W-1:0]     w_nMinusR;
    logic [W-1:0]     w_kLoad;
    logic [W-1:0]     w_factor;
    logic [2*W-1:0]   w_product;
    logic             w_mulOvf;
    logic             w_lastStep;
    logic [W:0]       w_remShift;
    logic             w_qBit;
    logic [W-1:0]     w_remSub;
    logic [W-1:0]     w_remNext;
    logic [2*W-1:0]   w_quoNext;
    logic             w_divLast;
    logic             w_divOvf;

    // n - r is only meaningful once r <= n; when r > n the err path ignores w_kLoad.
    assign w_rGtN     = r_r > r_n;
    assign w_nMinusR  = r_n - r_r;
    assign w_kLoad    = (r_mode && (w_nMinusR < r_r)) ? w_nMinusR : r_r;

    assign w_factor   = r_mode ? (r_n - r_k + r_i) : (r_n - r_i + W'(1));
    assign w_product  = {{W{1'b0}}, r_acc[W-1:0]} * {{W{1'b0}}, w_factor};
    assign w_mulOvf   = (w_product[2*W-1:W] != '0);
    assign w_lastStep = (r_i == r_k);

    // Restoring divide shifts the dividend out of r_acc while quotient bits shift in;
    // the partial remainder always stays below the divisor, so W bits suffice.
    assign w_remShift = {r_rem, r_acc[2*W-1]};
    assign w_qBit     = (w_remShift >= {1'b0, r_i});
    assign w_remSub   = w_remShift[W-1:0] - r_i;
    assign w_remNext  = w_qBit ? w_remSub : w_remShift[W-1:0];
    assign w_quoNext  = {r_acc[2*W-2:0], w_qBit};
    assign w_divLast  = (r_divCnt == DIV_LAST);
    assign w_divOvf   = (w_quoNext[2*W-1:W] != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_nextState = LOAD;
            end
            LOAD: begin
                if (w_rGtN || (w_kLoad == '0)) w_nextState = DONE;
                else                           w_nextState = MUL;
            end
            MUL: begin
                if (r_mode)                       w_nextState = DIV;
                else if (w_mulOvf || w_lastStep)  w_nextState = DONE;
            end
            DIV: begin
                if (w_divLast) begin
                    if (w_divOvf || w_lastStep) w_nextState = DONE;
                    else                        w_nextState = MUL;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // The result and flags are written on the transition into DONE and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= 1'b0;
            r_n      <= '0;
            r_r      <= '0;
            r_k      <= '0;
            r_i      <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_divCnt <= '0;
            r_out    <= '0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_n    <= n;
                        r_r    <= r;
                    end
                end
                LOAD: begin
                    r_err <= w_rGtN;
                    r_ovf <= 1'b0;
                    r_k   <= w_kLoad;
                    r_acc <= {{(2*W-1){1'b0}}, 1'b1};
                    r_i   <= W'(1);
                    if (w_rGtN)                r_out <= '0;
                    else if (w_kLoad == '0)    r_out <= W'(1);
                end
                MUL: begin
                    r_acc    <= w_product;
                    r_rem    <= '0;
                    r_divCnt <= '0;
                    if (!r_mode) begin
                        if (w_mulOvf) begin
                            r_ovf <= 1'b1;
                            r_out <= '1;
                        end else if (w_lastStep) begin
                            r_out <= w_product[W-1:0];
                        end else begin
                            r_i <= r_i + W'(1);
                        end
                    end
                end
                DIV: begin
                    r_acc    <= w_quoNext;
                    r_rem    <= w_remNext;
                    r_divCnt <= r_divCnt + CNT_W'(1);
                    if (w_divLast) begin
                        if (w_divOvf) begin
                            r_ovf <= 1'b1;
                            r_out <= '1;
                        end else if (w_lastStep) begin
                            r_out <= w_quoNext[W-1:0];
                        end else begin
                            r_i <= r_i + W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out = r_out;
    assign err = r_err;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_n_perm_comb_seq.sv
// Self-checking bench for n_perm_comb_seq: table of directed vectors, handshake and
// reset corner sequences, and random operands against a plain-arithmetic model.
module tb_n_perm_comb_seq;

    localparam int W       = 36;
    localparam int TIMEOUT = 3000;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic [W-1:0] n;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         err;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit           mode;
        logic [W-1:0] n;
        logic [W-1:0] r;
        logic [W-1:0] expOut;
        bit           expErr;
        bit           expOvf;
        int           expLat;
    } vec_t;

    vec_t vecs[$];

    n_perm_comb_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .n     (n),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .err   (err),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Textbook definitions: nPr = n(n-1)..(n-k+1); nCr built as C(n-k+i, i) step by step.
    function automatic void refModel(input bit m, input logic [W-1:0] nv, input logic [W-1:0] rv,
                                     output logic [W-1:0] eOut, output bit eErr,
                                     output bit eOvf, output int eLat);
        logic [127:0] val;
        logic [127:0] kk;
        logic [127:0] ii;
        logic [127:0] limit;
        int           steps;
        eErr  = 1'b0;
        eOvf  = 1'b0;
        eOut  = '0;
        eLat  = 2;
        if (rv > nv) begin
            eErr = 1'b1;
            return;
        end
        kk = 128'(rv);
        if (m && (128'(nv) - 128'(rv) < 128'(rv))) kk = 128'(nv) - 128'(rv);
        val   = 128'd1;
        limit = 128'd1 << W;
        steps = 0;
        ii    = 128'd1;
        while (ii <= kk) begin
            steps++;
            if (m) val = val * (128'(nv) - kk + ii) / ii;
            else   val = val * (128'(nv) - ii + 128'd1);
            if (val >= limit) begin
                eOvf = 1'b1;
                break;
            end
            ii = ii + 128'd1;
        end
        eOut = eOvf ? ONES : val[W-1:0];
        eLat = 2 + steps * (m ? (1 + 2 * W) : 1);
    endfunction

    task automatic applyStimulus(input bit m, input logic [W-1:0] nv, input logic [W-1:0] rv,
                                 output int lat, output int busyBefore, output bit timedOut,
                                 output logic [W-1:0] gotOut, output bit gotErr, output bit gotOvf,
                                 output bit busyAtDone, output bit pulseOk);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        n     = nv;
        r     = rv;
        @(negedge clk);
        start      = 1'b0;
        mode       = ~m;
        n          = W'($urandom());
        r          = W'($urandom());
        lat        = 1;
        busyBefore = 0;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            if (busy === 1'b1) busyBefore++;
            @(negedge clk);
            lat++;
        end
        timedOut   = (done !== 1'b1);
        gotOut     = out;
        gotErr     = err;
        gotOvf     = ovf;
        busyAtDone = busy;
        @(negedge clk);
        pulseOk = (done === 1'b0) && (busy === 1'b0);
    endtask

    task automatic runCheck(input string name, input bit m, input logic [W-1:0] nv,
                            input logic [W-1:0] rv, input logic [W-1:0] eOut, input bit eErr,
                            input bit eOvf, input int eLat);
        int           lat;
        int           busyBefore;
        bit           timedOut;
        logic [W-1:0] gotOut;
        bit           gotErr;
        bit           gotOvf;
        bit           busyAtDone;
        bit           pulseOk;
        applyStimulus(m, nv, rv, lat, busyBefore, timedOut, gotOut, gotErr, gotOvf,
                      busyAtDone, pulseOk);
        checkOutput({name, ".doneSeen"}, W'(!timedOut), W'(1));
        checkOutput({name, ".out"}, gotOut, eOut);
        checkOutput({name, ".err"}, W'(gotErr), W'(eErr));
        checkOutput({name, ".ovf"}, W'(gotOvf), W'(eOvf));
        checkOutput({name, ".latency"}, W'(lat), W'(eLat));
        checkOutput({name, ".busyCycles"}, W'(busyBefore), W'(eLat - 1));
        checkOutput({name, ".busyAtDone"}, W'(busyAtDone), W'(1));
        checkOutput({name, ".singlePulse"}, W'(pulseOk), W'(1));
    endtask

    initial begin
        int           lat;
        int           donePulses;
        logic [W-1:0] eOut;
        bit           eErr;
        bit           eOvf;
        int           eLat;
        bit           m;
        logic [W-1:0] nv;
        logic [W-1:0] rv;

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        n     = '0;
        r     = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset.busy", W'(busy), W'(0));
        checkOutput("reset.done", W'(done), W'(0));
        checkOutput("reset.out", out, W'(0));
        checkOutput("reset.err", W'(err), W'(0));
        checkOutput("reset.ovf", W'(ovf), W'(0));
        rst_n = 1'b1;

        vecs.push_back('{1'b0, W'(10), W'(3),  W'(720),        1'b0, 1'b0, 5});
        vecs.push_back('{1'b1, W'(10), W'(7),  W'(120),        1'b0, 1'b0, 221});
        vecs.push_back('{1'b1, W'(52), W'(5),  W'(2598960),    1'b0, 1'b0, 367});
        vecs.push_back('{1'b0, W'(5),  W'(7),  W'(0),          1'b1, 1'b0, 2});
        vecs.push_back('{1'b0, W'(5),  W'(0),  W'(1),          1'b0, 1'b0, 2});
        vecs.push_back('{1'b1, W'(5),  W'(0),  W'(1),          1'b0, 1'b0, 2});
        vecs.push_back('{1'b0, W'(30), W'(30), ONES,           1'b0, 1'b1, 10});
        vecs.push_back('{1'b0, W'(12), W'(12), W'(479001600),  1'b0, 1'b0, 14});
        vecs.push_back('{1'b0, W'(0),  W'(0),  W'(1),          1'b0, 1'b0, 2});
        vecs.push_back('{1'b1, W'(0),  W'(0),  W'(1),          1'b0, 1'b0, 2});
        vecs.push_back('{1'b1, W'(7),  W'(7),  W'(1),          1'b0, 1'b0, 2});
        vecs.push_back('{1'b1, W'(1),  W'(2),  W'(0),          1'b1, 1'b0, 2});
        vecs.push_back('{1'b1, W'(60), W'(30), ONES,           1'b0, 1'b1, 1024});
        vecs.push_back('{1'b1, W'(6),  W'(2),  W'(15),         1'b0, 1'b0, 148});

        for (int i = 0; i < vecs.size(); i++) begin
            runCheck($sformatf("vec%0d", i), vecs[i].mode, vecs[i].n, vecs[i].r,
                     vecs[i].expOut, vecs[i].expErr, vecs[i].expOvf, vecs[i].expLat);
        end

        // Starts while busy and during the DONE cycle must be dropped without queueing.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; n = W'(10); r = W'(3);
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        @(negedge clk);
        lat++;
        start = 1'b1; mode = 1'b1; n = W'(9); r = W'(4);
        @(negedge clk);
        lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("ignore.latency", W'(lat), W'(5));
        checkOutput("ignore.out", out, W'(720));
        start = 1'b1; mode = 1'b0; n = W'(8); r = W'(2);
        @(negedge clk);
        start = 1'b0;
        checkOutput("ignore.doneStart.busy", W'(busy), W'(0));
        checkOutput("ignore.doneStart.out", out, W'(720));
        runCheck("ignore.next", 1'b0, W'(8), W'(2), W'(56), 1'b0, 1'b0, 4);

        // Asynchronous reset in the middle of a divide aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; mode = 1'b1; n = W'(10); r = W'(5);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("midReset.busyBefore", W'(busy), W'(1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midReset.busy", W'(busy), W'(0));
        checkOutput("midReset.done", W'(done), W'(0));
        checkOutput("midReset.out", out, W'(0));
        checkOutput("midReset.err", W'(err), W'(0));
        checkOutput("midReset.ovf", W'(ovf), W'(0));
        donePulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) donePulses++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) donePulses++;
        end
        checkOutput("midReset.noDone", W'(donePulses), W'(0));
        checkOutput("midReset.idle", W'(busy), W'(0));
        runCheck("midReset.6C2", 1'b1, W'(6), W'(2), W'(15), 1'b0, 1'b0, 148);

        // Small operands cover full results and errors; huge n forces early overflow.
        for (int i = 0; i < 24; i++) begin
            m  = 1'(($urandom() >> 3) & 1);
            nv = m ? W'($urandom_range(0, 30)) : W'($urandom_range(0, 40));
            rv = W'($urandom_range(0, 32'(nv) + 2));
            refModel(m, nv, rv, eOut, eErr, eOvf, eLat);
            runCheck($sformatf("rand%0d_m%0d_n%0d_r%0d", i, m, nv, rv), m, nv, rv,
                     eOut, eErr, eOvf, eLat);
        end
        for (int i = 0; i < 6; i++) begin
            m  = 1'(($urandom() >> 5) & 1);
            nv = W'({$urandom(), $urandom()});
            rv = W'($urandom_range(0, 3));
            refModel(m, nv, rv, eOut, eErr, eOvf, eLat);
            runCheck($sformatf("big%0d_m%0d_r%0d", i, m, rv), m, nv, rv,
                     eOut, eErr, eOvf, eLat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/n_perm_comb_seq.md
Name: n_perm_comb_seq

Overview:
- Sequential combinatorics engine: computes nPr = n!/(n-r)! or nCr = n!/(r!(n-r)!) for one operand pair per start.
- Generalised successor to the factorial/division permutation path:
  - parametrised width;
  - mode select;
  - iterative product instead of two full factorials;
  - start/busy/done handshake;
  - error and overflow flags.
- Sits beside the factorial and division units in the combinatorics datapath.

Parameters:
- W, 36, operand and result width in bits.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = nPr, 1 = nCr; captured with start.
- n  input  W  unsigned n; captured with start.
- r  input  W  unsigned r; captured with start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when out/err/ovf are valid.
- out  output  W  result; holds until next DONE.
- err  output  1  r > n for the last operation.
- ovf  output  1  last result exceeded W bits.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset:
  - state = IDLE.
  - busy = 0, done = 0, out = 0, err = 0, ovf = 0.
  - Reset mid-operation aborts the operation; no done pulse.
- States: IDLE, LOAD, MUL, DIV, DONE.
- IDLE:
  - start = 1 → register n, r, mode; go to LOAD.
  - start while busy is ignored; no queueing.
- LOAD:
  - r > n → go to DONE with result 0, err = 1.
  - Otherwise set k = r (nPr) or k = min(r, n-r) (nCr); acc = 1 (2W bits); i = 1.
  - k = 0 → DONE with result 1.
  - Else → MUL.
- MUL (1 cycle):
  - nPr: acc = acc[W-1:0] * (n - i + 1).
  - nCr: acc = acc[W-1:0] * (n - k + i).
  - Full 2W-bit product.
  - nPr: acc[2W-1:W] != 0 → ovf; go to DONE.
  - nPr, no overflow: i == k → DONE; else i++ and stay in MUL.
  - nCr: → DIV.
- DIV (nCr only):
  - Restoring divide, acc / i, 2W-bit dividend, W-bit divisor.
  - Exactly 2W cycles, one quotient bit per cycle.
  - Quotient is exact: no remainder by construction.
  - Quotient bits [2W-1:W] != 0 → ovf; go to DONE.
  - Otherwise acc = quotient; i == k → DONE; else i++ and go to MUL.
- DONE (1 cycle):
  - done = 1.
  - out = acc[W-1:0], or all-ones if ovf, or 0 if err.
  - err/ovf updated; both cleared at the next LOAD.
  - Next state: IDLE.
- Latency, counted from the clk edge that samples start to the cycle done is high:
  - nPr: 2 + k cycles.
  - nCr: 2 + k·(1 + 2W) cycles.
  - err or k = 0: 2 cycles.
  - Overflow terminates early at the overflowing step.
- start asserted in the DONE cycle is ignored. Earliest next acceptance is the following IDLE cycle.
- Width rules:
  - All arithmetic is unsigned.
  - n - r computed only after r ≤ n is checked, so no wrap-around.
  - Loop counter i is W bits.
- Boundary results:
  - 0P0 = 1, 0C0 = 1.
  - nPn = n!.
  - nCn = 1 (k = 0).

Test Plan:
- Reset released; mode=0, n=10, r=3, start 1 cycle → out=720, done pulse exactly 5 cycles after start edge, err=0, ovf=0, busy high for 4 cycles.
- mode=1, n=10, r=7 (k=3) → out=120. mode=1, n=52, r=5 → out=2598960; done at 2+5·73=367 cycles for W=36.
- mode=0, n=5, r=7 → err=1, out=0, done at 2 cycles. Then n=5, r=0 in both modes → out=1, err cleared.
- W=36, mode=0, n=30, r=30 → ovf=1, out=36'hFFFFFFFFF, early done before 32 cycles. W=36, mode=0, n=12, r=12 → 479001600, ovf=0.
- start pulsed with different operands while busy and in the DONE cycle → ignored; first result unchanged. A new start one cycle later is accepted.
- rst_n asserted asynchronously mid-DIV → all outputs 0 immediately, no done. A fresh 6C2 completes with out=15.
